// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: synchronizes NMI/IRQ pins, arbitrates at instruction
// boundaries and walks the seven-step BRK-style service (push PC/P, fetch vector).
module interrupt_sequencer (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enableFFs,
  input  logic        nNMI,
  input  logic        nIRQ,
  input  logic        iFlag,
  input  logic        getInstruction,
  output logic        forceBreak,
  output logic [2:0]  serviceStep,
  output logic        pushEnable,
  output logic [1:0]  pushSelect,
  output logic [15:0] vectorAddress,
  output logic        vectorFetch,
  output logic        setIFlag,
  output logic        bFlag,
  output logic        serviceDone
);

  typedef enum logic {RUN, SERVICE} state_t;
  typedef enum logic {SRC_IRQ, SRC_NMI} src_t;

  localparam logic [15:0] NMI_BASE = 16'hFFFA;
  localparam logic [15:0] IRQ_BASE = 16'hFFFE;

  state_t      state;
  src_t        source;
  logic [2:0]  step;
  logic        nmi_s1, nmi_s2, nmi_s3;
  logic        irq_s1, irq_s2;
  logic        nmi_pending;
  logic        nmi_edge, irq_req, take, hijack, consume;
  logic [15:0] base;

  // Synchronizers and edge history run regardless of enableFFs; the reset value
  // of 1 means releasing reset with the pin high never looks like a falling edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      nmi_s1 <= 1'b1;
      nmi_s2 <= 1'b1;
      nmi_s3 <= 1'b1;
      irq_s1 <= 1'b1;
      irq_s2 <= 1'b1;
    end else begin
      nmi_s1 <= nNMI;
      nmi_s2 <= nmi_s1;
      nmi_s3 <= nmi_s2;
      irq_s1 <= nIRQ;
      irq_s2 <= irq_s1;
    end
  end

  assign nmi_edge = nmi_s3 & ~nmi_s2;
  assign irq_req  = ~irq_s2 & ~iFlag;
  assign take     = (state == RUN) && enableFFs && getInstruction && (nmi_pending || irq_req);
  assign hijack   = (state == SERVICE) && enableFFs && (source == SRC_IRQ) &&
                    nmi_pending && (step <= 3'd4);
  assign consume  = (take && nmi_pending) || hijack;

  // A new edge wins over consumption so an NMI arriving in the consume cycle is kept.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      nmi_pending <= 1'b0;
    end else if (nmi_edge) begin
      nmi_pending <= 1'b1;
    end else if (consume) begin
      nmi_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= RUN;
      step   <= 3'd0;
      source <= SRC_IRQ;
    end else if (enableFFs) begin
      case (state)
        RUN: begin
          if (take) begin
            state  <= SERVICE;
            step   <= 3'd0;
            source <= nmi_pending ? SRC_NMI : SRC_IRQ;
          end
        end
        SERVICE: begin
          if (step == 3'd6) begin
            state <= RUN;
            step  <= 3'd0;
          end else begin
            step <= step + 3'd1;
            if (hijack) source <= SRC_NMI;
          end
        end
        default: begin
          state <= RUN;
          step  <= 3'd0;
        end
      endcase
    end
  end

  assign base = (source == SRC_NMI) ? NMI_BASE : IRQ_BASE;

  // Outputs decode only registered state, so reset clears them immediately;
  // the step-6 pulses are qualified by enableFFs so a stall cannot stretch them.
  always_comb begin
    forceBreak    = 1'b0;
    serviceStep   = step;
    pushEnable    = 1'b0;
    pushSelect    = 2'd0;
    vectorAddress = 16'h0000;
    vectorFetch   = 1'b0;
    setIFlag      = 1'b0;
    serviceDone   = 1'b0;
    bFlag         = 1'b0;
    if (state == SERVICE) begin
      forceBreak = 1'b1;
      case (step)
        3'd2: begin pushEnable = 1'b1; pushSelect = 2'd0; end
        3'd3: begin pushEnable = 1'b1; pushSelect = 2'd1; end
        3'd4: begin pushEnable = 1'b1; pushSelect = 2'd2; end
        3'd5: begin vectorFetch = 1'b1; vectorAddress = base; end
        3'd6: begin
          vectorFetch   = 1'b1;
          vectorAddress = base + 16'd1;
          setIFlag      = enableFFs;
          serviceDone   = enableFFs;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all flops on rising edge.
REQ-002 SHALL have port nrst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port enableFFs, input, 1, global advance enable; low = stall.
REQ-004 SHALL have port nNMI, input, 1, asynchronous active-low NMI pin; falling edge requests.
REQ-005 SHALL have port nIRQ, input, 1, asynchronous active-low IRQ pin; level requests.
REQ-006 SHALL have port iFlag, input, 1, processor interrupt-disable flag; 1 masks IRQ.
REQ-007 SHALL have port getInstruction, input, 1, instruction-boundary strobe from control logic.
REQ-008 SHALL have port forceBreak, output, 1, substitute BRK sequence for the fetched opcode.
REQ-009 SHALL have port serviceStep, output, 3, current service step 0-6; 0 when idle.
REQ-010 SHALL have port pushEnable, output, 1, stack write this cycle.
REQ-011 SHALL have port pushSelect, output, 2, 0=PCH, 1=PCL, 2=P.
REQ-012 SHALL have port vectorAddress, output, 16, vector fetch address; 0 when not fetching.
REQ-013 SHALL have port vectorFetch, output, 1, vectorAddress valid.
REQ-014 SHALL have port setIFlag, output, 1, one-cycle pulse to set I.
REQ-015 SHALL have port bFlag, output, 1, B value for pushed P; always 0 here.
REQ-016 SHALL have port serviceDone, output, 1, one-cycle pulse on service completion.

Function
REQ-017 SHALL pass nNMI and nIRQ each through a 2-flop synchronizer before any use.
REQ-018 SHALL set nmiPending on a synchronized 1->0 nNMI transition; nmiPending SHALL hold until consumed.
REQ-019 SHALL keep synchronizers, edge detector and nmiPending setting active while enableFFs=0; all other state SHALL freeze.
REQ-020 SHALL treat IRQ as requesting when synchronized nIRQ=0 and iFlag=0, sampled at the boundary cycle only.
REQ-021 SHALL implement states RUN and SERVICE; SERVICE SHALL contain steps 0..6.
REQ-022 SHALL move RUN->SERVICE, step 0, on a cycle with getInstruction=1, enableFFs=1 and a request present.
REQ-023 SHALL latch source NMI when nmiPending=1 at entry, else IRQ; simultaneous NMI and IRQ SHALL select NMI.
REQ-024 SHALL clear nmiPending in the entry cycle when NMI is selected; an edge in that same cycle SHALL re-set it.
REQ-025 SHALL advance one step per cycle with enableFFs=1 and hold the step with enableFFs=0.
REQ-026 SHALL assert forceBreak during all SERVICE steps.
REQ-027 SHALL assert pushEnable at steps 2, 3, 4 with pushSelect 0, 1, 2 respectively.
REQ-028 SHALL assert vectorFetch at steps 5 and 6 with vectorAddress base and base+1.
REQ-029 SHALL use base 16'hFFFA for NMI and 16'hFFFE for IRQ.
REQ-030 SHALL hijack IRQ service: if nmiPending=1 at steps 0-4 of IRQ service, source SHALL switch to NMI at the next step and nmiPending SHALL clear.
REQ-031 SHALL not hijack at steps 5-6; a pending NMI then SHALL wait for the next boundary.
REQ-032 SHALL pulse setIFlag at step 6 for either source.
REQ-033 SHALL leave step 6 to RUN with serviceDone pulsed in the step-6 advance cycle.
REQ-034 SHALL ignore getInstruction while in SERVICE.
REQ-035 SHALL hold bFlag=0 at all times.

Reset
REQ-036 SHALL, on nrst=0, set state RUN, step 0, nmiPending 0, source IRQ, synchronizer flops 1.
REQ-037 SHALL, during reset, drive forceBreak, pushEnable, vectorFetch, setIFlag, serviceDone 0, pushSelect 0, vectorAddress 16'h0000.
REQ-038 SHALL abort any in-progress service immediately on reset with no completion pulse.
REQ-039 SHALL not detect an NMI edge from reset release alone.

Verification
REQ-040 SHALL verify: nIRQ=0, iFlag=0, getInstruction pulse -> 7 SERVICE cycles, pushes PCH/PCL/P at steps 2-4, FFFE/FFFF at steps 5-6, setIFlag and serviceDone at step 6.
REQ-041 SHALL verify: nIRQ=0, iFlag=1, boundary -> stays RUN, forceBreak=0.
REQ-042 SHALL verify: nNMI falls, nIRQ=0, same boundary -> NMI vector FFFA; IRQ not serviced until next boundary.
REQ-043 SHALL verify: IRQ service, NMI edge at step 2 -> vectors FFFA/FFFB, nmiPending 0 afterward.
REQ-044 SHALL verify: enableFFs=0 for 3 cycles at step 3 with NMI edge meanwhile -> step holds at 3, nmiPending=1, then hijack on resume.
REQ-045 SHALL verify: nrst asserted at step 4 -> all outputs 0 at once, RUN after release, no serviceDone.
